// File: rtl/alarm_annunciator_if.sv
// Alarm annunciator bus: key/alarm levels in, LED and snooze display out.
// master drives the inputs (timer datapath, keys); slave is the annunciator.
interface alarm_annunciator_if;
   logic       alarm_in;
   logic       dismiss;
   logic       snooze;
   logic [7:0] ledg;
   logic       ringing;
   logic       snoozing;
   logic [1:0] snooze_count;
   logic [3:0] remain1;
   logic [3:0] remain2;

   modport master (
      output alarm_in, dismiss, snooze,
      input  ledg, ringing, snoozing, snooze_count, remain1, remain2
   );

   modport slave (
      input  alarm_in, dismiss, snooze,
      output ledg, ringing, snoozing, snooze_count, remain1, remain2
   );
endinterface

// File: rtl/alarm_annunciator.sv
// Alarm annunciator: ring/snooze/dismiss FSM driving LEDs and BCD countdown.
// Ports: clk, resetn (sync, active-high), bus (alarm_annunciator_if.slave).
module alarm_annunciator #(
   parameter int TICK_DIV   = 25_000_000,
   parameter int SNOOZE_S   = 10,
   parameter int TIMEOUT_S  = 60,
   parameter int MAX_SNOOZE = 3
) (
   input  logic                clk,
   input  logic                resetn,
   alarm_annunciator_if.slave  bus
);

   localparam logic [24:0] TICK_LAST = 25'(TICK_DIV - 1);
   localparam logic [6:0]  SNZ       = 7'(SNOOZE_S);
   localparam logic [6:0]  TMO       = 7'(TIMEOUT_S);
   localparam logic [1:0]  MAX_C     = 2'(MAX_SNOOZE);

   typedef enum logic [1:0] {IDLE, RING, SNOOZE, DONE} state_t;

   state_t      state_q, state_d;
   logic        alarm_q, dismiss_q, snooze_q;
   logic        rise_alarm, rise_dismiss, rise_snooze;
   logic [24:0] tick_q, tick_d;
   logic        half_q, half_d;
   logic [6:0]  sec_q, sec_d;
   logic [6:0]  rem_q, rem_d;
   logic [7:0]  led_q, led_d;
   logic [1:0]  cnt_q, cnt_d;
   logic        tick;
   logic [3:0]  tens, ones;

   assign rise_alarm   = bus.alarm_in & ~alarm_q;
   assign rise_dismiss = bus.dismiss & ~dismiss_q;
   assign rise_snooze  = bus.snooze & ~snooze_q;
   assign tick         = (tick_q == TICK_LAST);

   always_ff @(posedge clk) begin
      if (resetn) begin
         state_q   <= IDLE;
         alarm_q   <= 1'b0;
         dismiss_q <= 1'b0;
         snooze_q  <= 1'b0;
         tick_q    <= '0;
         half_q    <= 1'b0;
         sec_q     <= '0;
         rem_q     <= '0;
         led_q     <= '0;
         cnt_q     <= '0;
      end else begin
         state_q   <= state_d;
         alarm_q   <= bus.alarm_in;
         dismiss_q <= bus.dismiss;
         snooze_q  <= bus.snooze;
         tick_q    <= tick_d;
         half_q    <= half_d;
         sec_q     <= sec_d;
         rem_q     <= rem_d;
         led_q     <= led_d;
         cnt_q     <= cnt_d;
      end
   end

   // half_q marks the second tick of each one-second pair
   always_comb begin
      state_d = state_q;
      tick_d  = tick ? '0 : tick_q + 25'd1;
      half_d  = half_q ^ tick;
      sec_d   = sec_q;
      rem_d   = rem_q;
      led_d   = led_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE: begin
            tick_d = '0;
            half_d = 1'b0;
            led_d  = 8'h00;
            if (rise_alarm) begin
               state_d = RING;
               cnt_d   = '0;
               sec_d   = '0;
               led_d   = 8'h55;
            end
         end
         RING: begin
            if (rise_dismiss) begin
               state_d = DONE;
               led_d   = 8'h00;
            end else if (rise_snooze && cnt_q < MAX_C) begin
               state_d = SNOOZE;
               cnt_d   = cnt_q + 2'd1;
               rem_d   = SNZ;
               led_d   = 8'h01;
            end else if (tick) begin
               led_d = ~led_q;
               if (half_q) begin
                  sec_d = sec_q + 7'd1;
                  if (sec_q + 7'd1 == TMO) begin
                     state_d = DONE;
                     led_d   = 8'h00;
                  end
               end
            end
         end
         SNOOZE: begin
            if (rise_dismiss) begin
               state_d = DONE;
               led_d   = 8'h00;
            end else if (tick) begin
               led_d = {7'd0, ~led_q[0]};
               if (half_q) begin
                  if (rem_q == 7'd1) begin
                     state_d = RING;
                     sec_d   = '0;
                     led_d   = 8'h55;
                  end else begin
                     rem_d = rem_q - 7'd1;
                  end
               end
            end
         end
         DONE: begin
            tick_d = '0;
            half_d = 1'b0;
            led_d  = 8'h00;
            if (!bus.alarm_in) state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
      // every state change restarts the tick timebase
      if (state_d != state_q) begin
         tick_d = '0;
         half_d = 1'b0;
      end
   end

   assign tens = 4'(rem_q / 7'd10);
   assign ones = 4'(rem_q % 7'd10);

   assign bus.ledg         = led_q;
   assign bus.ringing      = (state_q == RING);
   assign bus.snoozing     = (state_q == SNOOZE);
   assign bus.snooze_count = cnt_q;
   assign bus.remain1      = (state_q == SNOOZE) ? tens : 4'd0;
   assign bus.remain2      = (state_q == SNOOZE) ? ones : 4'd0;

endmodule

// File: tb/tb_alarm_annunciator.sv
// Bench for alarm_annunciator: directed scenarios plus random key traffic,
// checked every cycle against an elapsed-time reference model.
module tb_alarm_annunciator;

   localparam int TD  = 4;
   localparam int SS  = 3;
   localparam int TO  = 5;
   localparam int MX  = 2;

   localparam int M_IDLE   = 0;
   localparam int M_RING   = 1;
   localparam int M_SNOOZE = 2;
   localparam int M_DONE   = 3;

   logic clk = 1'b0;
   logic resetn;
   alarm_annunciator_if bus ();

   alarm_annunciator #(
      .TICK_DIV   (TD),
      .SNOOZE_S   (SS),
      .TIMEOUT_S  (TO),
      .MAX_SNOOZE (MX)
   ) dut (
      .clk    (clk),
      .resetn (resetn),
      .bus    (bus)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_pass = 0;
   int n_fail = 0;

   int m_mode = M_IDLE;
   int m_el   = 0;
   int m_cnt  = 0;
   int pa = 0, pd = 0, ps = 0;

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got == exp) begin
         n_pass++;
      end else begin
         n_fail++;
         if (n_fail <= 40)
            $display("FAIL %s t=%0t got %0h want %0h", tag, $time, got, exp);
      end
   endtask

   // Model: mode plus cycles elapsed since entering it.
   task automatic m_step(input int a, input int d, input int s, input int r);
      int ra, rd, rs;
      if (r != 0) begin
         m_mode = M_IDLE;
         m_cnt  = 0;
         m_el   = 0;
         pa = 0; pd = 0; ps = 0;
         return;
      end
      ra = a & ~pa;
      rd = d & ~pd;
      rs = s & ~ps;
      case (m_mode)
         M_IDLE: if (ra != 0) begin
            m_mode = M_RING; m_el = 0; m_cnt = 0;
         end
         M_RING: begin
            if (rd != 0) m_mode = M_DONE;
            else if (rs != 0 && m_cnt < MX) begin
               m_mode = M_SNOOZE; m_el = 0; m_cnt++;
            end else if (m_el + 1 == 2 * TD * TO) m_mode = M_DONE;
            else m_el++;
         end
         M_SNOOZE: begin
            if (rd != 0) m_mode = M_DONE;
            else if (m_el + 1 == 2 * TD * SS) begin
               m_mode = M_RING; m_el = 0;
            end else m_el++;
         end
         default: if (a == 0) m_mode = M_IDLE;
      endcase
      pa = a; pd = d; ps = s;
   endtask

   task automatic check_all();
      int led, rem;
      led = 0;
      rem = 0;
      if (m_mode == M_RING)
         led = ((m_el / TD) % 2 == 1) ? 8'hAA : 8'h55;
      if (m_mode == M_SNOOZE) begin
         led = ((m_el / TD) % 2 == 1) ? 0 : 1;
         rem = SS - m_el / (2 * TD);
      end
      chk("ledg", int'(bus.ledg), led);
      chk("ringing", int'(bus.ringing), int'(m_mode == M_RING));
      chk("snoozing", int'(bus.snoozing), int'(m_mode == M_SNOOZE));
      chk("snooze_count", int'(bus.snooze_count), m_cnt);
      chk("remain1", int'(bus.remain1), rem / 10);
      chk("remain2", int'(bus.remain2), rem % 10);
   endtask

   // Apply inputs at negedge, clock once, check at next negedge.
   task automatic cyc(input int a, input int d, input int s, input int r);
      bus.alarm_in = a[0];
      bus.dismiss  = d[0];
      bus.snooze   = s[0];
      resetn       = r[0];
      m_step(a, d, s, r);
      @(posedge clk);
      @(negedge clk);
      check_all();
   endtask

   task automatic run(input int n, input int a, input int d, input int s);
      for (int i = 0; i < n; i++) cyc(a, d, s, 0);
   endtask

   initial begin
      int a, d, s, r;
      bus.alarm_in = 1'b0;
      bus.dismiss  = 1'b0;
      bus.snooze   = 1'b0;
      resetn       = 1'b1;
      @(negedge clk);
      for (int i = 0; i < 3; i++) cyc(0, 0, 0, 1);
      run(2, 0, 0, 0);
      // ring pattern
      run(10, 1, 0, 0);
      // snooze then expiry back to ring
      cyc(1, 0, 1, 0);
      run(26, 1, 0, 0);
      // second snooze, then a third at the limit, then dismiss
      cyc(1, 0, 1, 0);
      run(26, 1, 0, 0);
      cyc(1, 0, 1, 0);
      run(3, 1, 0, 0);
      cyc(1, 1, 0, 0);
      run(2, 1, 0, 0);
      run(3, 0, 0, 0);
      // timeout, then held snooze in DONE
      run(42, 1, 0, 0);
      run(3, 1, 0, 1 - 1);
      run(3, 1, 0, 1);
      // simultaneous dismiss and snooze
      run(2, 0, 0, 0);
      run(3, 1, 0, 0);
      cyc(1, 1, 1, 0);
      run(2, 1, 0, 0);
      // reset mid-snooze, alarm high at release counts as a rise
      run(2, 0, 0, 0);
      run(2, 1, 0, 0);
      cyc(1, 0, 1, 0);
      run(5, 1, 0, 0);
      cyc(1, 0, 0, 1);
      cyc(1, 0, 0, 1);
      run(5, 1, 0, 0);
      // held alarm in DONE, dismiss held, fall then rise
      run(12, 1, 1, 0);
      cyc(0, 1, 0, 0);
      run(4, 1, 1, 0);
      run(3, 1, 0, 0);
      // random traffic
      a = 1; d = 0; s = 0;
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 39) == 0) a = 1 - a;
         d = ($urandom_range(0, 59) == 0) ? 1 - d : d;
         if ($urandom_range(0, 11) == 0) s = 1 - s;
         r = ($urandom_range(0, 599) == 0) ? 1 : 0;
         cyc(a, d, s, r);
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule

// File: doc/alarm_annunciator.md
# alarm_annunciator

Alarm annunciator stage downstream of the clock/timer datapath. Consumes the sticky `alarm_out` level and drives the green LED bank with a ring pattern. Handles snooze and dismiss keys, with a bounded snooze count and an auto-timeout. Exports the snooze countdown as two BCD digits for the existing `hex_decoder_9MAX` displays.

## Interface
Parameters:
- `TICK_DIV`, 25_000_000 — clk cycles per half-second tick (50 MHz clock).
- `SNOOZE_S`, 10 — snooze length in seconds; legal range 1..99.
- `TIMEOUT_S`, 60 — seconds of continuous ringing before auto-stop; legal range 1..127.
- `MAX_SNOOZE`, 3 — snoozes allowed per alarm event; legal range 0..3.

Ports:
- `clk  in  1` — single system clock.
- `resetn  in  1` — synchronous, active-high reset; the name is kept for consistency with the rest of the design.
- `alarm_in  in  1` — alarm level from the timer datapath; sticky-high while the alarm is expired.
- `dismiss  in  1` — active-high dismiss key level, already inverted from KEY.
- `snooze  in  1` — active-high snooze key level.
- `ledg  out  8` — LED pattern.
- `ringing  out  1` — high in RING.
- `snoozing  out  1` — high in SNOOZE.
- `snooze_count  out  2` — snoozes used in the current alarm event.
- `remain1  out  4` — BCD tens of snooze seconds remaining.
- `remain2  out  4` — BCD ones of snooze seconds remaining.

## Operation
Input edge detection:
- `alarm_in`, `dismiss` and `snooze` are each registered once (`*_q`).
- `rise_x = x & ~x_q`, evaluated combinationally.
- Only rising edges act; held levels are ignored.

States: IDLE, RING, SNOOZE, DONE.
- **IDLE:**
  - Outputs: `ledg`=0, `remain`=00.
  - On `rise_alarm`: go to RING, `snooze_count`=0.
- **RING:**
  - Entry: `ledg`=8'h55, tick counter=0, ring-second counter=0.
  - Each tick toggles `ledg` between 8'h55 and 8'hAA. Every second tick increments the ring-second counter.
  - Priority per cycle: `rise_dismiss` → DONE; else `rise_snooze` with `snooze_count`<`MAX_SNOOZE` → SNOOZE and `snooze_count`+1; else ring-second counter reaching `TIMEOUT_S` → DONE.
  - `rise_snooze` at the snooze limit is ignored.
- **SNOOZE:**
  - Entry: remaining = `SNOOZE_S`, `ledg`=8'h01, tick counter=0.
  - Each tick toggles `ledg[0]`; `ledg[7:1]`=0.
  - Remaining decrements every second tick.
  - Decrement from 1 → RING (fresh RING entry, timeout restarts).
  - `rise_dismiss` → DONE; `rise_snooze` ignored.
- **DONE:**
  - Outputs: `ledg`=0, `remain`=00.
  - When `alarm_in`=0 → IDLE.
  - A still-high `alarm_in` never re-triggers RING.

Arithmetic:
- Tick counter is 25 bits and counts 0..`TICK_DIV`-1. It runs only in RING and SNOOZE and clears on every state change.
- Ring-second counter is 7 bits.
- Remaining is held in binary (7 bits) and converted to BCD tens/ones combinationally.
- `remain1`/`remain2` show remaining in SNOOZE only, 0 in every other state.

## Timing
- Reset (synchronous, `resetn`=1):
  - State goes to IDLE.
  - All outputs go to 0, `snooze_count`=0.
  - All counters and `*_q` registers go to 0.
  - Reset overrides every other input, including mid-RING or mid-SNOOZE.
- Because `*_q` resets to 0, `alarm_in` high at reset release counts as a rise.
- Latency: input high at posedge N → new state and outputs visible after posedge N (one cycle).
- RING timeout: exactly 2·`TICK_DIV`·`TIMEOUT_S` cycles after RING entry, absent key edges.
- SNOOZE duration: exactly 2·`TICK_DIV`·`SNOOZE_S` cycles.
  - Remaining steps down once every 2·`TICK_DIV` cycles.
- Simultaneous events:
  - `dismiss` beats `snooze`.
  - `dismiss` beats timeout or snooze expiry; result is DONE in every case.
  - In DONE, `alarm_in` falling and rising on consecutive cycles: the fall goes to IDLE, the rise then goes to RING.

## Test plan
Parameters for all scenarios: `TICK_DIV`=4, `SNOOZE_S`=3, `TIMEOUT_S`=5, `MAX_SNOOZE`=2.
1. Reset, then raise `alarm_in` → next cycle `ringing`=1, `ledg`=55; after 4 cycles `ledg`=AA; after 8 cycles `ledg`=55.
2. In RING, pulse `snooze` → `snoozing`=1, `remain`=0/3, `snooze_count`=1. Remain shows 2 after 8 cycles and 1 after 16. After 24 cycles `ringing`=1, `remain`=0/0.
3. Snooze twice, then a third `snooze` pulse → stays RING with `snooze_count`=2. Then `dismiss` → `ledg`=0, `ringing`=0. Drop `alarm_in` → IDLE.
4. No key input in RING → after 40 cycles `ringing`=0 (DONE). Raise `snooze` while still held → no effect.
5. `dismiss` and `snooze` rising on the same cycle in RING → DONE, `snooze_count` unchanged. Separately, assert `resetn` mid-SNOOZE → all outputs 0, state IDLE.
6. Hold `alarm_in` high through DONE → no re-ring. Hold `dismiss` high continuously → no repeated action. Lower then raise `alarm_in` → RING with `snooze_count`=0.
